// File: rtl/npu_sigmoid_sched.sv
// Round-robin scheduler sharing one sigmoid unit across NUM_PE PEs; define NPU_SIGMOID_SCHED_STATS_EN for stall/issue counters.
// Latency: fixed 3 cycles from grant to FIFO write strobe; layer_done follows once the pipeline has drained.
// Backpressure: a PE is granted only while its destination FIFO is not almost-full; ops in flight never stall.
module npu_sigmoid_sched #(
    parameter int NUM_PE   = 8,
    parameter int PE_IDX_W = 3
) (
    input  logic                   CLK,
    input  logic                   npu_rst_n,
    input  logic                   cfg_start,
    input  logic [15:0]            cfg_op_count,
    input  logic [NUM_PE-1:0]      pe_req,
    input  logic [48*NUM_PE-1:0]   pe_data,
    input  logic [2*NUM_PE-1:0]    pe_func_sel,
    input  logic [NUM_PE-1:0]      pe_dest,
    output logic [NUM_PE-1:0]      pe_grant,
    output logic [47:0]            npu_sigmoid_din,
    output logic [1:0]             npu_sched_sigmoid_function_sel,
    input  logic [15:0]            npu_sigmoid_dout,
    input  logic                   sig_fifo_afull,
    input  logic                   out_fifo_afull,
    output logic                   sig_fifo_wr,
    output logic                   out_fifo_wr,
    output logic [15:0]            fifo_wdata,
    output logic [PE_IDX_W-1:0]    fifo_wtag,
    output logic                   sched_busy,
    output logic                   layer_done,
    output logic [31:0]            stat_stall_cycles,
    output logic [31:0]            stat_issued
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [PE_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]           op_count_q, op_count_d;
    logic [15:0]           issued_q, issued_d;

    logic                  s1_vld_q, s1_vld_d;
    logic [47:0]           din_q, din_d;
    logic [1:0]            s1_sel_q, s1_sel_d;
    logic                  s1_dest_q, s1_dest_d;
    logic [PE_IDX_W-1:0]   s1_tag_q, s1_tag_d;

    logic                  s2_vld_q, s2_vld_d;
    logic [1:0]            fsel_q, fsel_d;
    logic                  s2_dest_q, s2_dest_d;
    logic [PE_IDX_W-1:0]   s2_tag_q, s2_tag_d;

    logic                  sig_wr_q, sig_wr_d;
    logic                  out_wr_q, out_wr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [PE_IDX_W-1:0]   wtag_q, wtag_d;

    logic [NUM_PE-1:0]     eligible;
    logic                  found;
    logic [PE_IDX_W-1:0]   winner;
    logic [PE_IDX_W-1:0]   idx_w;
    int                    idx;
    logic                  xfer;
    logic                  start_acc;
    logic [47:0]           win_data;
    logic [1:0]            win_sel;
    logic                  win_dest;

    // Rotating priority search starting at rr_ptr, wrapping at NUM_PE.
    always_comb begin
        eligible = '0;
        found    = 1'b0;
        winner   = '0;
        idx      = 0;
        idx_w    = '0;
        for (int i = 0; i < NUM_PE; i++)
            eligible[i] = pe_req[i] & ~(pe_dest[i] ? out_fifo_afull : sig_fifo_afull);
        for (int k = 0; k < NUM_PE; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_PE)
                idx = idx - NUM_PE;
            idx_w = idx[PE_IDX_W-1:0];
            if (!found && eligible[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
        xfer     = (state_q == RUN) && found;
        pe_grant = '0;
        if (xfer)
            pe_grant[winner] = 1'b1;
    end

    always_comb begin
        win_data = '0;
        win_sel  = '0;
        win_dest = 1'b0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (winner == PE_IDX_W'(i)) begin
                win_data = pe_data[48*i +: 48];
                win_sel  = pe_func_sel[2*i +: 2];
                win_dest = pe_dest[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        op_count_d = op_count_q;
        issued_d   = issued_q;
        rr_ptr_d   = rr_ptr_q;
        start_acc  = (state_q == IDLE) && cfg_start;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    op_count_d = cfg_op_count;
                    issued_d   = '0;
                    state_d    = (cfg_op_count == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer && (issued_q + 16'd1 == op_count_q))
                    state_d = DRAIN;
            end
            // S3 retires on the same edge, so S1/S2 empty means nothing is left after it.
            DRAIN: begin
                if (!s1_vld_q && !s2_vld_q)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (xfer) begin
            issued_d = issued_q + 16'd1;
            rr_ptr_d = (winner == PE_IDX_W'(NUM_PE - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_comb begin
        s1_vld_d  = xfer;
        din_d     = xfer ? win_data : din_q;
        s1_sel_d  = xfer ? win_sel  : s1_sel_q;
        s1_dest_d = xfer ? win_dest : s1_dest_q;
        s1_tag_d  = xfer ? winner   : s1_tag_q;

        s2_vld_d  = s1_vld_q;
        fsel_d    = s1_vld_q ? s1_sel_q : 2'd3;
        s2_dest_d = s1_dest_q;
        s2_tag_d  = s1_tag_q;

        sig_wr_d  = s2_vld_q && !s2_dest_q;
        out_wr_d  = s2_vld_q &&  s2_dest_q;
        wdata_d   = s2_vld_q ? npu_sigmoid_dout : wdata_q;
        wtag_d    = s2_vld_q ? s2_tag_q : wtag_q;
    end

    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            op_count_q <= '0;
            issued_q   <= '0;
            s1_vld_q   <= 1'b0;
            din_q      <= '0;
            s1_sel_q   <= '0;
            s1_dest_q  <= 1'b0;
            s1_tag_q   <= '0;
            s2_vld_q   <= 1'b0;
            fsel_q     <= 2'd3;
            s2_dest_q  <= 1'b0;
            s2_tag_q   <= '0;
            sig_wr_q   <= 1'b0;
            out_wr_q   <= 1'b0;
            wdata_q    <= '0;
            wtag_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            op_count_q <= op_count_d;
            issued_q   <= issued_d;
            s1_vld_q   <= s1_vld_d;
            din_q      <= din_d;
            s1_sel_q   <= s1_sel_d;
            s1_dest_q  <= s1_dest_d;
            s1_tag_q   <= s1_tag_d;
            s2_vld_q   <= s2_vld_d;
            fsel_q     <= fsel_d;
            s2_dest_q  <= s2_dest_d;
            s2_tag_q   <= s2_tag_d;
            sig_wr_q   <= sig_wr_d;
            out_wr_q   <= out_wr_d;
            wdata_q    <= wdata_d;
            wtag_q     <= wtag_d;
        end
    end

    assign npu_sigmoid_din                = din_q;
    assign npu_sched_sigmoid_function_sel = fsel_q;
    assign sig_fifo_wr                    = sig_wr_q;
    assign out_fifo_wr                    = out_wr_q;
    assign fifo_wdata                     = wdata_q;
    assign fifo_wtag                      = wtag_q;
    assign sched_busy                     = (state_q != IDLE);
    assign layer_done                     = (state_q == DONE);

`ifdef NPU_SIGMOID_SCHED_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] issued_cnt_q, issued_cnt_d;

    always_comb begin
        stall_d      = stall_q;
        issued_cnt_d = issued_cnt_q;
        if (start_acc) begin
            stall_d      = '0;
            issued_cnt_d = '0;
        end else begin
            if ((state_q == RUN) && (|pe_req) && !xfer && (stall_q != 32'hFFFF_FFFF))
                stall_d = stall_q + 32'd1;
            if (xfer && (issued_cnt_q != 32'hFFFF_FFFF))
                issued_cnt_d = issued_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            stall_q      <= '0;
            issued_cnt_q <= '0;
        end else begin
            stall_q      <= stall_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign stat_stall_cycles = stall_q;
    assign stat_issued       = issued_cnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc  = start_acc;
    assign stat_stall_cycles = '0;
    assign stat_issued       = '0;
`endif

endmodule

// File: tb/tb_npu_sigmoid_sched.sv
// Bench for npu_sigmoid_sched: directed layers, a stub sigmoid unit, and a grant/write scoreboard.
module tb_npu_sigmoid_sched;
    localparam int NUM_PE = 8;
    localparam int W      = 3;

    logic                 CLK;
    logic                 npu_rst_n;
    logic                 cfg_start;
    logic [15:0]          cfg_op_count;
    logic [NUM_PE-1:0]    pe_req;
    logic [48*NUM_PE-1:0] pe_data;
    logic [2*NUM_PE-1:0]  pe_func_sel;
    logic [NUM_PE-1:0]    pe_dest;
    logic [NUM_PE-1:0]    pe_grant;
    logic [47:0]          din;
    logic [1:0]           fsel;
    logic [15:0]          dout;
    logic                 sig_fifo_afull, out_fifo_afull;
    logic                 sig_fifo_wr, out_fifo_wr;
    logic [15:0]          fifo_wdata;
    logic [W-1:0]         fifo_wtag;
    logic                 sched_busy, layer_done;
    logic [31:0]          stat_stall_cycles, stat_issued;

    npu_sigmoid_sched #(.NUM_PE(NUM_PE), .PE_IDX_W(W)) dut (
        .CLK                            (CLK),
        .npu_rst_n                      (npu_rst_n),
        .cfg_start                      (cfg_start),
        .cfg_op_count                   (cfg_op_count),
        .pe_req                         (pe_req),
        .pe_data                        (pe_data),
        .pe_func_sel                    (pe_func_sel),
        .pe_dest                        (pe_dest),
        .pe_grant                       (pe_grant),
        .npu_sigmoid_din                (din),
        .npu_sched_sigmoid_function_sel (fsel),
        .npu_sigmoid_dout               (dout),
        .sig_fifo_afull                 (sig_fifo_afull),
        .out_fifo_afull                 (out_fifo_afull),
        .sig_fifo_wr                    (sig_fifo_wr),
        .out_fifo_wr                    (out_fifo_wr),
        .fifo_wdata                     (fifo_wdata),
        .fifo_wtag                      (fifo_wtag),
        .sched_busy                     (sched_busy),
        .layer_done                     (layer_done),
        .stat_stall_cycles              (stat_stall_cycles),
        .stat_issued                    (stat_issued)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Stub sigmoid unit, 1-cycle latency: sel0 = din[23:8]^5A5A, sel1 = din[22:7], else 0.
    logic [47:0] unit_din_q = '0;
    always @(posedge CLK) unit_din_q <= din;
    always_comb begin
        case (fsel)
            2'd0:    dout = unit_din_q[23:8] ^ 16'h5A5A;
            2'd1:    dout = unit_din_q[22:7];
            default: dout = 16'h0000;
        endcase
    end

    typedef struct packed {
        logic         dest;
        logic [W-1:0] tag;
        logic [15:0]  data;
    } wr_t;

    wr_t  exp_wr[$];
    int   exp_gnt[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_grant_cyc = 0;
    int   wr_seen = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected grants and writes whenever the DUT presents them.
    int          mon_g;
    wr_t         mon_e;
    logic [7:0]  mon_m;
    always @(negedge CLK) begin
        if (npu_rst_n) begin
            if (pe_grant != '0) begin
                last_grant_cyc = cyc;
                if (exp_gnt.size() == 0) begin
                    check("gnt_unexpected", pe_grant, 0);
                end else begin
                    mon_g = exp_gnt.pop_front();
                    mon_m = '0;
                    mon_m[mon_g] = 1'b1;
                    check("gnt", pe_grant, mon_m);
                end
            end
            if (sig_fifo_wr || out_fifo_wr) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", {sig_fifo_wr, out_fifo_wr}, 0);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("wr", {sig_fifo_wr, out_fifo_wr, fifo_wtag, fifo_wdata},
                          {~mon_e.dest, mon_e.dest, mon_e.tag, mon_e.data});
                end
            end
        end
    end

    task automatic set_pe(input int i, input logic [47:0] d, input logic [1:0] s, input logic dst);
        pe_data[48*i +: 48]   = d;
        pe_func_sel[2*i +: 2] = s;
        pe_dest[i]            = dst;
    endtask

    task automatic expect_op(input int pe, input logic dst, input logic [15:0] d);
        wr_t e;
        e.dest = dst;
        e.tag  = W'(pe);
        e.data = d;
        exp_gnt.push_back(pe);
        exp_wr.push_back(e);
    endtask

    task automatic start_layer(input logic [15:0] n);
        @(posedge CLK); #1;
        cfg_start    = 1'b1;
        cfg_op_count = n;
        @(posedge CLK); #1;
        cfg_start    = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        npu_rst_n      = 1'b0;
        pe_req         = '0;
        cfg_start      = 1'b0;
        sig_fifo_afull = 1'b0;
        out_fifo_afull = 1'b0;
        repeat (2) @(posedge CLK);
        #1 npu_rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name, output int done_at);
        bit seen;
        seen    = 1'b0;
        done_at = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge CLK);
            if (layer_done) begin
                seen    = 1'b1;
                done_at = cyc;
            end
        end
        check(name, seen, 1);
    endtask

    task automatic set_ramp(input logic [1:0] s);
        for (int i = 0; i < NUM_PE; i++)
            set_pe(i, 48'(i) << 7, s, 1'b0);
    endtask

    initial begin
        int s_cyc, d_cyc, w0;
        npu_rst_n      = 1'b0;
        cfg_start      = 1'b0;
        cfg_op_count   = '0;
        pe_req         = '0;
        pe_data        = '0;
        pe_func_sel    = '0;
        pe_dest        = '0;
        sig_fifo_afull = 1'b0;
        out_fifo_afull = 1'b0;

        @(negedge CLK);
        check("rst_fsel", fsel, 2'd3);
        check("rst_busy", sched_busy, 0);
        check("rst_grant", pe_grant, 0);
        do_reset();

        // Single tanh op to the sigmoid FIFO, cycle-exact timing.
        set_pe(0, 48'h100, 2'd0, 1'b0);
        pe_req = 8'h01;
        expect_op(0, 1'b0, 16'h5A5B);
        start_layer(16'd1);
        @(negedge CLK);
        check("t2_grant_A", pe_grant, 8'h01);
        @(posedge CLK); #1 pe_req = '0;
        @(negedge CLK);
        check("t2_sel_A1", fsel, 2'd3);
        check("t2_din_A1", din, 48'h100);
        @(negedge CLK);
        check("t2_sel_A2", fsel, 2'd0);
        @(negedge CLK);
        check("t2_wr_A3", {sig_fifo_wr, out_fifo_wr, fifo_wtag}, {2'b10, 3'd0});
        @(negedge CLK);
        check("t2_done_A4", layer_done, 1);
        @(negedge CLK);
        check("t2_done_A5", layer_done, 0);
        check("t2_busy_A5", sched_busy, 0);

        // Linear op to the output FIFO, then the same operand with a zero select.
        set_pe(2, 48'h3F80, 2'd1, 1'b1);
        pe_req = 8'h04;
        expect_op(2, 1'b1, 16'h007F);
        start_layer(16'd1);
        @(posedge CLK); #1 pe_req = '0;
        wait_done("t3a_done", d_cyc);
        set_pe(2, 48'h3F80, 2'd3, 1'b1);
        pe_req = 8'h04;
        expect_op(2, 1'b1, 16'h0000);
        start_layer(16'd1);
        @(posedge CLK); #1 pe_req = '0;
        wait_done("t3b_done", d_cyc);

        // All PEs requesting: two full round-robin sweeps back to back.
        do_reset();
        set_ramp(2'd1);
        pe_req = 8'hFF;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_PE; i++)
                expect_op(i, 1'b0, 16'(i));
        start_layer(16'd16);
        s_cyc = cyc;
        wait_done("t4_done", d_cyc);
        pe_req = '0;
        check("t4_consecutive", last_grant_cyc - s_cyc, 15);
        check("t4_done_lat", d_cyc - last_grant_cyc, 4);

        // Output FIFO almost-full masks PEs 1 and 3 until released.
        do_reset();
        set_ramp(2'd1);
        pe_dest = 8'b0000_1010;
        pe_req  = 8'hFF;
        out_fifo_afull = 1'b1;
        expect_op(0, 1'b0, 16'd0);
        expect_op(2, 1'b0, 16'd2);
        expect_op(4, 1'b0, 16'd4);
        expect_op(5, 1'b0, 16'd5);
        expect_op(6, 1'b0, 16'd6);
        expect_op(7, 1'b0, 16'd7);
        expect_op(0, 1'b0, 16'd0);
        expect_op(1, 1'b1, 16'd1);
        expect_op(2, 1'b0, 16'd2);
        expect_op(3, 1'b1, 16'd3);
        start_layer(16'd10);
        repeat (6) @(posedge CLK);
        #1 out_fifo_afull = 1'b0;
        wait_done("t5_done", d_cyc);
        pe_req  = '0;
        pe_dest = '0;

        // Reset in flight after three transfers: nothing may be written afterwards.
        do_reset();
        set_ramp(2'd1);
        pe_req = 8'hFF;
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        exp_gnt.push_back(2);
        start_layer(16'd8);
        repeat (3) @(posedge CLK);
        #1;
        npu_rst_n = 1'b0;
        pe_req    = '0;
        w0        = wr_seen;
        @(negedge CLK);
        check("t1_grant", pe_grant, 0);
        check("t1_din", din, 0);
        check("t1_fsel", fsel, 2'd3);
        check("t1_wr", {sig_fifo_wr, out_fifo_wr}, 0);
        check("t1_wdata", {fifo_wdata, fifo_wtag}, 0);
        check("t1_busy_done", {sched_busy, layer_done}, 0);
        check("t1_stats", {stat_stall_cycles, stat_issued}, 0);
        @(posedge CLK); #1 npu_rst_n = 1'b1;
        repeat (10) @(negedge CLK);
        check("t6_no_wr", wr_seen - w0, 0);

        // Zero-length layer: done the cycle after start, no grants.
        pe_req = 8'hFF;
        start_layer(16'd0);
        @(negedge CLK);
        check("t6_zero_done", {layer_done, sched_busy}, 2'b11);
        @(negedge CLK);
        check("t6_zero_done_end", layer_done, 0);
        pe_req = '0;
        repeat (3) @(negedge CLK);

        check("sb_wr_empty", exp_wr.size(), 0);
        check("sb_gnt_empty", exp_gnt.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1, "watchdog");
    end

endmodule
